branch_resolve_bht: RTL and testbench
=====================================

// Module: branch_resolve_bht
// PURPOSE
//  Parametrised branch unit: decode-stage branch resolution plus a PC-indexed
//  table of saturating counters. Fetch reads a taken/not-taken prediction.
//  Decode resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, flags mispredicts and trains the
//  table one cycle later. Also keeps branch and mispredict statistics counters.
// PARAMETERS
//  XLEN        32  operand/PC width
//  BHT_ENTRIES 64  counter table depth; power of 2, >=4
//  CNT_BITS    2   saturating counter width, 2..4
//  GHR_BITS    6   global history length; only used with BHT_GSHARE_EN;
//                  must be <= log2(BHT_ENTRIES)
// PORTS
//  clk            in   1     single clock, rising edge
//  reset_n        in   1     synchronous, active-low reset
//  pcF            in   XLEN  fetch PC to predict
//  predict_takenF out  1     prediction for pcF (combinational)
//  branchD        in   1     decode instr is a conditional branch
//  funct3D        in   3     branch condition code
//  srca, srcb     in   XLEN  forwarded rs1/rs2 values
//  pcD            in   XLEN  decode PC
//  pred_takenD    in   1     prediction carried from fetch with the instr
//  stallD         in   1     decode stalled; instr not yet resolved
//  br_takenD      out  1     resolved outcome (combinational)
//  mispredictD    out  1     resolved outcome != pred_takenD (combinational)
//  br_count       out  32    resolved branches since reset
//  mispred_count  out  32    mispredicts since reset
// BEHAVIOUR
//  - One clock and one reset: clk, with synchronous active-low reset_n.
//  - IDX = log2(BHT_ENTRIES). Table index = pc[IDX+1:2].
//  - br_takenD by funct3D:
//      000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
//    Output is 0 when branchD=0 or funct3D is 010/011.
//  - resolve = branchD & !stallD & (funct3D is a legal branch code).
//    mispredictD = resolve & (br_takenD != pred_takenD).
//    Illegal funct3: no update, no count, mispredictD=0.
//  - predict_takenF = MSB of the counter at the fetch index.
//  - Update pipeline: on a resolve cycle, register upd_valid=1, upd_idx, upd_taken.
//    On the next edge, the counter at upd_idx gets +1 if taken, -1 if not taken.
//    Counters saturate at all-ones and zero; they never wrap.
//  - Bypass: when upd_valid and fetch index == upd_idx, predict_takenF uses the
//    post-update counter value (read-after-write forwarding). Same cycle, no stall.
//  - Back-to-back resolves to the same index each apply in order, one per cycle.
//  - stallD=1: no update, no count, mispredictD=0; br_takenD stays valid.
//  - br_count increments on each resolve. mispred_count increments when
//    mispredictD=1. Both saturate at 32'hFFFF_FFFF. Registered: visible next cycle.
//  - Reset (also mid-operation): every counter = weakly not-taken (0b01 << (CNT_BITS-2)).
//    br_count = mispred_count = 0; upd_valid = 0, so a pending update is dropped;
//    GHR = 0.
// CONFIGURATION
//  - BHT_GSHARE_EN defined:
//      fetch index = pc index XOR {zero-ext GHR}; resolve index = pcD index XOR
//      GHR value in the resolve cycle.
//      GHR shifts in upd_taken (LSB) on the same edge as the counter update.
//      The bypass compares these hashed indices.
//  - BHT_GSHARE_EN undefined: bimodal PC indexing only; no GHR state exists and
//    GHR_BITS is ignored.
// TESTING
//  - Reset, then pcF=0x100 -> predict_takenF=0; both counts =0.
//  - BLT srca=0xFFFF_FFFF srcb=1 pred=0 -> br_takenD=1, mispredictD=1;
//    next cycle mispred_count=1, br_count=1.
//  - BGEU same operands -> br_takenD=1. BLTU same operands -> br_takenD=0.
//  - Two taken resolves at pcD=0x100, with pcF=0x100 held -> predict_takenF=1 in
//    the cycle after the 1st update (bypass). Three not-taken -> back to 0;
//    a 4th not-taken leaves the counter saturated at 0.
//  - stallD=1 with a taken BEQ -> br_takenD=1, mispredictD=0, counts unchanged.
//    reset_n low during the update cycle -> table stays at reset value.
//  - BHT_GSHARE_EN: pcD=0x40 taken, then pcF=0x40 -> predicts from the index
//    0x10^GHR(=1)=0x11. Bimodal build reads index 0x10.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// ----------------------------------------------------------------------------
// branch_resolve_bht
//   Decode-stage conditional branch resolution combined with a PC-indexed
//   table of saturating taken/not-taken counters and branch statistics.
//
//   Fetch side : pcF is hashed to a table index and the counter MSB is
//                returned as predict_takenF. A pending training update to
//                the same index is forwarded so fetch never sees stale data.
//   Decode side: BEQ/BNE/BLT/BGE/BLTU/BGEU are evaluated on srca/srcb.
//                A resolving branch (not stalled, legal funct3) registers a
//                training update that is written into the table one edge
//                later, and bumps the saturating statistics counters.
//
// Ports
//   clk, reset_n      rising-edge clock, synchronous active-low reset
//   pcF               fetch PC            -> predict_takenF (comb)
//   branchD, funct3D  decode branch valid and condition code
//   srca, srcb        forwarded operands
//   pcD, pred_takenD  decode PC and the prediction that fetched it
//   stallD            decode stalled: outcome shown but not acted on
//   br_takenD         resolved outcome (comb)
//   mispredictD       resolving and outcome != pred_takenD (comb)
//   br_count          resolved branches since reset (registered, saturating)
//   mispred_count     mispredicts since reset (registered, saturating)
//
// Build option
//   BHT_GSHARE_EN : when defined, table indices are XORed with a GHR_BITS
//                   global history register (gshare). Undefined = bimodal.
// ----------------------------------------------------------------------------
module branch_resolve_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int GHR_BITS    = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pcF,
  output logic            predict_takenF,
  input  logic            branchD,
  input  logic [2:0]      funct3D,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [XLEN-1:0] pcD,
  input  logic            pred_takenD,
  input  logic            stallD,
  output logic            br_takenD,
  output logic            mispredictD,
  output logic [31:0]     br_count,
  output logic [31:0]     mispred_count
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  // Weakly not-taken: MSB clear, next-lower bit set.
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1) << (CNT_BITS - 2);

  // --------------------------------------------------------------------------
  // Helper functions
  // --------------------------------------------------------------------------
  function automatic logic [CNT_BITS-1:0] cnt_step(input logic [CNT_BITS-1:0] cnt,
                                                   input logic               taken);
    logic [CNT_BITS-1:0] res;
    if (taken) begin
      if (cnt == {CNT_BITS{1'b1}}) res = cnt;
      else                         res = cnt + CNT_BITS'(1);
    end else begin
      if (cnt == {CNT_BITS{1'b0}}) res = cnt;
      else                         res = cnt - CNT_BITS'(1);
    end
    return res;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    logic [31:0] res;
    if (val == 32'hFFFF_FFFF) res = val;
    else                      res = val + 32'd1;
    return res;
  endfunction

  function automatic logic funct3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_BITS-1:0] bht_q [BHT_ENTRIES];
  logic                upd_valid_q, upd_valid_d;
  logic [IDX-1:0]      upd_idx_q, upd_idx_d;
  logic                upd_taken_q, upd_taken_d;
  logic [31:0]         br_count_q, br_count_d;
  logic [31:0]         mispred_count_q, mispred_count_d;

  logic [IDX-1:0]      pcf_idx_s, pcd_idx_s;
  logic [IDX-1:0]      fetch_idx_s, res_idx_s;
  logic [CNT_BITS-1:0] upd_cnt_s;
  logic [CNT_BITS-1:0] fetch_cnt_s;
  logic                cond_s;
  logic                resolve_s;

  assign pcf_idx_s = pcF[IDX+1:2];
  assign pcd_idx_s = pcD[IDX+1:2];

`ifdef BHT_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Both lookups hash with the history as it stands this cycle.
  assign fetch_idx_s = pcf_idx_s ^ IDX'(ghr_q);
  assign res_idx_s   = pcd_idx_s ^ IDX'(ghr_q);

  // History advances with the same edge that writes the counter.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_q) begin
      ghr_d = GHR_BITS'({ghr_q, upd_taken_q});
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Global history register.
  always_ff @(posedge clk) begin
    if (!reset_n) ghr_q <= {GHR_BITS{1'b0}};
    else          ghr_q <= ghr_d;
  end

  logic unused_s;
  assign unused_s = ^{pcF[XLEN-1:IDX+2], pcF[1:0], pcD[XLEN-1:IDX+2], pcD[1:0]};
`else
  assign fetch_idx_s = pcf_idx_s;
  assign res_idx_s   = pcd_idx_s;

  logic unused_s;
  assign unused_s = ^{pcF[XLEN-1:IDX+2], pcF[1:0], pcD[XLEN-1:IDX+2], pcD[1:0],
                      1'(GHR_BITS)};
`endif

  // --------------------------------------------------------------------------
  // Branch condition evaluation
  // --------------------------------------------------------------------------
  // Compare operands according to funct3; illegal codes never take.
  always_comb begin
    cond_s = 1'b0;
    case (funct3D)
      3'b000:  cond_s = (srca == srcb);
      3'b001:  cond_s = (srca != srcb);
      3'b100:  cond_s = ($signed(srca) <  $signed(srcb));
      3'b101:  cond_s = ($signed(srca) >= $signed(srcb));
      3'b110:  cond_s = (srca <  srcb);
      3'b111:  cond_s = (srca >= srcb);
      default: cond_s = 1'b0;
    endcase
  end

  assign br_takenD   = branchD & cond_s;
  assign resolve_s   = branchD & ~stallD & funct3_legal(funct3D);
  assign mispredictD = resolve_s & (br_takenD != pred_takenD);

  // --------------------------------------------------------------------------
  // Prediction read with forwarding of the pending update
  // --------------------------------------------------------------------------
  assign upd_cnt_s = cnt_step(bht_q[upd_idx_q], upd_taken_q);

  // A pending write to the fetch index is forwarded so fetch sees its result.
  always_comb begin
    fetch_cnt_s = bht_q[fetch_idx_s];
    if (upd_valid_q && (upd_idx_q == fetch_idx_s)) begin
      fetch_cnt_s = upd_cnt_s;
    end else begin
      fetch_cnt_s = bht_q[fetch_idx_s];
    end
  end

  assign predict_takenF = fetch_cnt_s[CNT_BITS-1];

  // --------------------------------------------------------------------------
  // Update pipeline and statistics next-state
  // --------------------------------------------------------------------------
  // Capture the training request and bump counters on a resolve.
  always_comb begin
    upd_valid_d     = resolve_s;
    upd_idx_d       = upd_idx_q;
    upd_taken_d     = upd_taken_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (resolve_s) begin
      upd_idx_d   = res_idx_s;
      upd_taken_d = br_takenD;
      br_count_d  = sat_inc32(br_count_q);
    end else begin
      upd_idx_d   = upd_idx_q;
      upd_taken_d = upd_taken_q;
      br_count_d  = br_count_q;
    end
    if (mispredictD) begin
      mispred_count_d = sat_inc32(mispred_count_q);
    end else begin
      mispred_count_d = mispred_count_q;
    end
  end

  // Update-request and statistics registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      upd_valid_q     <= 1'b0;
      upd_idx_q       <= {IDX{1'b0}};
      upd_taken_q     <= 1'b0;
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      upd_valid_q     <= upd_valid_d;
      upd_idx_q       <= upd_idx_d;
      upd_taken_q     <= upd_taken_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Counter table: reset to weakly not-taken, written one edge after resolve.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (upd_valid_q) begin
      bht_q[upd_idx_q] <= upd_cnt_s;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pcF;
  logic        predict_takenF;
  logic        branchD;
  logic [2:0]  funct3D;
  logic [31:0] srca, srcb, pcD;
  logic        pred_takenD, stallD;
  logic        br_takenD, mispredictD;
  logic [31:0] br_count, mispred_count;

  always #5 clk = ~clk;

  branch_resolve_bht #(
    .XLEN(32), .BHT_ENTRIES(64), .CNT_BITS(2), .GHR_BITS(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pcF(pcF), .predict_takenF(predict_takenF),
    .branchD(branchD), .funct3D(funct3D), .srca(srca), .srcb(srcb), .pcD(pcD),
    .pred_takenD(pred_takenD), .stallD(stallD), .br_takenD(br_takenD),
    .mispredictD(mispredictD), .br_count(br_count), .mispred_count(mispred_count)
  );

  typedef struct {
    logic        pred;
    logic        taken;
    logic        misp;
    logic [31:0] brc;
    logic [31:0] mpc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  logic [1:0]  m_tbl [64];
  logic        m_pv;
  logic [5:0]  m_pidx;
  logic        m_pt;
  logic [31:0] m_brc, m_mpc;
  logic [5:0]  m_ghr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    else   return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic m_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
    m_pv = 1'b0; m_pidx = 6'd0; m_pt = 1'b0;
    m_brc = 32'd0; m_mpc = 32'd0; m_ghr = 6'd0;
  endtask

  // one clock of stimulus: drive, predict, compare at negedge, advance model
  task automatic step(input logic br, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pcd, input logic [31:0] pcf,
                      input logic pt, input logic st, input logic rn);
    exp_t       e, o;
    logic [5:0] fi, ri;
    logic [1:0] c;
    logic       tk, rs, legal;
    branchD = br; funct3D = f3; srca = a; srcb = b; pcD = pcd; pcF = pcf;
    pred_takenD = pt; stallD = st; reset_n = rn;
    fi = pcf[7:2] ^ m_ghr;
    ri = pcd[7:2] ^ m_ghr;
    c  = m_tbl[fi];
    if (m_pv && (m_pidx == fi)) c = m_sat(m_tbl[m_pidx], m_pt);
    legal = (f3 != 3'b010) && (f3 != 3'b011);
    tk = br && m_cond(f3, a, b);
    rs = br && !st && legal;
    e.pred = c[1]; e.taken = tk; e.misp = rs && (tk != pt);
    e.brc = m_brc; e.mpc = m_mpc;
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    chk("predict_takenF", {31'd0, predict_takenF}, {31'd0, o.pred});
    chk("br_takenD",      {31'd0, br_takenD},      {31'd0, o.taken});
    chk("mispredictD",    {31'd0, mispredictD},    {31'd0, o.misp});
    chk("br_count",       br_count,                o.brc);
    chk("mispred_count",  mispred_count,           o.mpc);
    @(posedge clk);
    if (!rn) begin
      m_reset();
    end else begin
      if (m_pv) begin
        m_tbl[m_pidx] = m_sat(m_tbl[m_pidx], m_pt);
`ifdef BHT_GSHARE_EN
        m_ghr = {m_ghr[4:0], m_pt};
`endif
      end
      m_pv = rs; m_pidx = ri; m_pt = tk;
      if (rs && m_brc != 32'hFFFF_FFFF) m_brc = m_brc + 32'd1;
      if (e.misp && m_mpc != 32'hFFFF_FFFF) m_mpc = m_mpc + 32'd1;
    end
    #1;
  endtask

  initial begin
    logic [31:0] pcs [5];
    logic [31:0] ra, rb;
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h40; pcs[4] = 32'h44;
    reset_n = 1'b0; branchD = 1'b0; funct3D = 3'b000; srca = 32'd0; srcb = 32'd0;
    pcD = 32'd0; pcF = 32'd0; pred_takenD = 1'b0; stallD = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    m_reset();

    // reset state
    step(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'h100, 1'b0, 1'b0, 1'b1);
    // BLT -1 < 1 mispredicted, BGEU taken, BLTU not taken
    step(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h100, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h204, 32'h100, 1'b0, 1'b0, 1'b1);
    chk("br_count_after3", br_count, 32'd3);
    chk("mispred_after3",  mispred_count, 32'd1);
    // remaining codes, equal and unequal operands
    step(1'b1, 3'b000, 32'd9, 32'd9, 32'h20C, 32'h100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b001, 32'd9, 32'd9, 32'h20C, 32'h100, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b101, 32'h8000_0000, 32'd0, 32'h20C, 32'h100, 1'b1, 1'b0, 1'b1);
    // train index of 0x100: two taken, three not taken, one more not taken
    step(1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h100, 1'b0, 1'b0, 1'b1);
    chk("bypass_predict", {31'd0, predict_takenF}, 32'd1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'b001, 32'd5, 32'd5, 32'h100, 32'h100, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'h100, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'h100, 1'b0, 1'b0, 1'b1);
    // stalled taken BEQ: outcome visible, no action
    step(1'b1, 3'b000, 32'd7, 32'd7, 32'h100, 32'h100, 1'b0, 1'b1, 1'b1);
    // illegal codes
    step(1'b1, 3'b010, 32'd1, 32'd1, 32'h100, 32'h100, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b011, 32'd1, 32'd2, 32'h100, 32'h100, 1'b1, 1'b0, 1'b1);
    // reset during the update cycle drops the pending write
    step(1'b1, 3'b000, 32'd3, 32'd3, 32'h108, 32'h108, 1'b1, 1'b0, 1'b1);
    step(1'b1, 3'b000, 32'd3, 32'd3, 32'h108, 32'h108, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'h108, 1'b0, 1'b0, 1'b1);
    chk("reset_drops_update", {31'd0, predict_takenF}, 32'd0);
    // history-sensitive lookup at 0x40
    step(1'b1, 3'b000, 32'd1, 32'd1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b000, 32'd1, 32'd1, 32'h40, 32'h40, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 1'b1);
    step(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'h44, 1'b0, 1'b0, 1'b1);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? ra : $urandom;
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb,
           pcs[$urandom_range(0, 4)], pcs[$urandom_range(0, 4)],
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 60) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
